shift_right_iter: RTL and testbench

Multi-cycle right shifter for the 16-bit datapath, the opposite direction of the existing left-shift stage. It accepts an operand, a 4-bit count and a mode, then retires the count at up to 2 bit positions per clock. Supported modes are logical, arithmetic and, optionally, rotate right. It sits beside the ALU shifter for shift-right instructions where area matters more than latency, and uses a valid/ready handshake on both sides.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_right_iter_if.sv | 25 ++
 rtl/mux2_cell.sv | 9 +
 rtl/shift_right_step.sv | 51 +++++
 rtl/shift_right_iter.sv | 75 +++++++
 tb/tb_shift_right_iter.sv | 142 ++++++++++++++
 6 files changed

// File: rtl/shift_pkg.sv
// Shared mode encodings and FSM state type for the iterative right shifter.
package shift_pkg;

  localparam logic [1:0] SHR_LOGICAL = 2'b00;
  localparam logic [1:0] SHR_ARITH   = 2'b01;
  localparam logic [1:0] SHR_ROTATE  = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } shr_state_e;

endpackage

// File: rtl/shift_right_iter_if.sv
// Valid/ready operand and result bundle for shift_right_iter.
interface shift_right_iter_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] In;
    logic [CNT_W-1:0] Cnt;
    logic [1:0]       Mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;

    modport master (
        output in_valid, In, Cnt, Mode, out_ready,
        input  in_ready, out_valid, Out
    );

    modport slave (
        input  in_valid, In, Cnt, Mode, out_ready,
        output in_ready, out_valid, Out
    );
endinterface

// File: rtl/mux2_cell.sv
// Single-bit 2:1 mux cell shared by the shift stages.
module mux2_cell (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/shift_right_step.sv
// Combinational right-shift-by-1-or-2 stage, one mux2_cell per bit.
// Rotate fill exists only when SHIFT_RIGHT_ROTATE_EN is defined.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] In,
    input  logic             Two,
    input  logic [1:0]       Mode,
    output logic [WIDTH-1:0] Out
);
    logic             fill1, fill2_hi, fill2_lo;
    logic [WIDTH-1:0] src1, src2;

    always_comb begin
        fill1    = 1'b0;
        fill2_hi = 1'b0;
        fill2_lo = 1'b0;
        if (Mode == SHR_ARITH) begin
            fill1    = In[WIDTH-1];
            fill2_hi = In[WIDTH-1];
            fill2_lo = In[WIDTH-1];
        end
`ifdef SHIFT_RIGHT_ROTATE_EN
        else if (Mode == SHR_ROTATE) begin
            // Bits leaving the LSB end wrap into the vacated MSBs.
            fill1    = In[0];
            fill2_hi = In[1];
            fill2_lo = In[0];
        end
`endif
    end

`ifndef SHIFT_RIGHT_ROTATE_EN
    logic unused_lsb;
    assign unused_lsb = In[0];
`endif

    assign src1 = {fill1, In[WIDTH-1:1]};
    assign src2 = {fill2_hi, fill2_lo, In[WIDTH-1:2]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2_cell u_mux (
            .a  (src1[i]),
            .b  (src2[i]),
            .sel(Two),
            .y  (Out[i])
        );
    end
endmodule

// File: rtl/shift_right_iter.sv
// Multi-cycle right shifter: retires up to 2 bit positions per clock.
// Optional rotate mode enabled by SHIFT_RIGHT_ROTATE_EN.
module shift_right_iter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    shift_right_iter_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    shr_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             two;
    logic [WIDTH-1:0] step_out;

    assign two = (rem_q >= CNT_W'(2));

    shift_right_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .In  (data_q),
        .Two (two),
        .Mode(mode_q),
        .Out (step_out)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d  = bus.In;
                    rem_d   = bus.Cnt;
                    mode_d  = bus.Mode;
                    state_d = (bus.Cnt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                data_d = step_out;
                rem_d  = rem_q - (two ? CNT_W'(2) : CNT_W'(1));
                if (rem_q <= CNT_W'(2)) state_d = StDone;
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= SHR_LOGICAL;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.Out       = data_q;
endmodule

// File: tb/tb_shift_right_iter.sv
// Directed self-checking bench for shift_right_iter (honours SHIFT_RIGHT_ROTATE_EN).
module tb_shift_right_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_right_iter_if #(.WIDTH(16)) bus ();

    shift_right_iter #(
        .WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operand, then wait (bounded) for out_valid and check result and latency.
    task automatic start_and_wait(input string tag, input logic [15:0] din,
                                  input logic [3:0] cnt, input logic [1:0] mode,
                                  input logic [15:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.In       = din;
        bus.Cnt      = cnt;
        bus.Mode     = mode;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.In       = 16'hDEAD;
        bus.Cnt      = 4'hF;
        bus.Mode     = 2'b01;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, 32'(bus.Out), 32'(exp));
        check({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] din, input logic [3:0] cnt,
                          input logic [1:0] mode, input logic [15:0] exp, input int exp_lat);
        start_and_wait(tag, din, cnt, mode, exp, exp_lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.In        = '0;
        bus.Cnt       = '0;
        bus.Mode      = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out", 32'(bus.Out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("logical4", 16'h8001, 4'd4, 2'b00, 16'h0800, 3);
        run_op("arith15", 16'h8000, 4'd15, 2'b01, 16'hFFFF, 9);
        run_op("zero_cnt", 16'hA5A5, 4'd0, 2'b00, 16'hA5A5, 1);
        run_op("arith1", 16'h8001, 4'd1, 2'b01, 16'hC000, 2);
        run_op("arith_pos", 16'h7000, 4'd3, 2'b01, 16'h0E00, 3);
        run_op("logical15", 16'hFFFF, 4'd15, 2'b00, 16'h0001, 9);
        run_op("reserved", 16'hF000, 4'd3, 2'b11, 16'h1E00, 3);
`ifdef SHIFT_RIGHT_ROTATE_EN
        run_op("rotate4", 16'h8001, 4'd4, 2'b10, 16'h1800, 3);
        run_op("rotate1", 16'h0003, 4'd1, 2'b10, 16'h8001, 2);
        run_op("rotate3", 16'h0005, 4'd3, 2'b10, 16'hA000, 3);
        run_op("rotate8", 16'h1234, 4'd8, 2'b10, 16'h3412, 5);
`else
        run_op("rotate4", 16'h8001, 4'd4, 2'b10, 16'h0800, 3);
        run_op("rotate1", 16'h0003, 4'd1, 2'b10, 16'h0001, 2);
        run_op("rotate3", 16'h0005, 4'd3, 2'b10, 16'h0000, 3);
        run_op("rotate8", 16'h1234, 4'd8, 2'b10, 16'h0012, 5);
`endif

        // Back-pressure: DONE must hold steady while out_ready is low.
        bus.out_ready = 1'b0;
        start_and_wait("bp", 16'h00F0, 4'd4, 2'b00, 16'h000F, 3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_out", 32'(bus.Out), 32'h000F);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);

        // Reset two cycles into a long operation.
        @(negedge clk);
        bus.In       = 16'h8000;
        bus.Cnt      = 4'd15;
        bus.Mode     = 2'b01;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out", 32'(bus.Out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op("after_rst", 16'h0004, 4'd2, 2'b00, 16'h0001, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
